// File: rtl/clk_mon.sv
// Derived-clock monitor: synchronises pe_clk/cell_clk, emits rise strobes, measures periods, tracks lock and sticky errors.
// Optional duty measurement outputs (pe_high/cell_high) are built when CLK_MON_DUTY_EN is defined.

module clk_mon_chan #(
    parameter int DIV      = 8,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             clk_in,
    output logic             rise,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             err_set
`ifdef CLK_MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] high
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int               MW     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(2 * DIV);
    localparam logic [MW-1:0]    LAST_C = MW'(LOCK_CNT - 1);

    logic             s1_r, s2_r, s3_r, rise_r;
    logic [CNT_W-1:0] cnt_r, cnt_s, period_r, period_s;
    logic [MW-1:0]    match_r, match_s;
    logic             locked_r, locked_s, err_set_s;
    state_t           state_r, state_s;

    // Synchroniser, history flop and registered rise strobe
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            s3_r   <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            s1_r   <= clk_in;
            s2_r   <= s1_r;
            s3_r   <= s2_r;
            rise_r <= s2_r & ~s3_r;
        end
    end

    // Channel state, period counter and measurement registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            match_r  <= '0;
            period_r <= '0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            match_r  <= match_s;
            period_r <= period_s;
            locked_r <= locked_s;
        end
    end

    // Next-state: period check on each strobe, timeout when the counter reaches twice the nominal period
    always_comb begin
        state_s   = state_r;
        match_s   = match_r;
        cnt_s     = cnt_r;
        period_s  = period_r;
        locked_s  = locked_r;
        err_set_s = 1'b0;
        if (rise_r) begin
            cnt_s = CNT_W'(1);
            case (state_r)
                IDLE: begin
                    state_s = LOCKING;
                    match_s = '0;
                end
                LOCKING: begin
                    period_s = cnt_r;
                    if (cnt_r == DIV_C) begin
                        match_s = match_r + MW'(1);
                        if (match_r == LAST_C) begin
                            state_s  = LOCKED;
                            locked_s = 1'b1;
                        end else begin
                            state_s = LOCKING;
                        end
                    end else begin
                        match_s = '0;
                    end
                end
                LOCKED: begin
                    period_s = cnt_r;
                    if (cnt_r != DIV_C) begin
                        state_s   = LOCKING;
                        match_s   = '0;
                        locked_s  = 1'b0;
                        err_set_s = 1'b1;
                    end else begin
                        state_s = LOCKED;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    cnt_s    = '0;
                    match_s  = '0;
                    locked_s = 1'b0;
                end
            endcase
        end else if (state_r == IDLE) begin
            cnt_s = '0;
        end else if (cnt_r == TMO_C) begin
            state_s   = IDLE;
            cnt_s     = '0;
            match_s   = '0;
            locked_s  = 1'b0;
            err_set_s = (state_r == LOCKED);
        end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    assign rise    = rise_r;
    assign period  = period_r;
    assign locked  = locked_r;
    assign err_set = err_set_s;

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_r, high_r;

    // Count synchronised-high cycles per period; s3 is high on the strobe cycle itself
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_r <= '0;
            high_r <= '0;
        end else if (rise_r) begin
            if (state_r != IDLE) begin
                high_r <= hcnt_r;
            end else begin
                high_r <= high_r;
            end
            hcnt_r <= {{(CNT_W-1){1'b0}}, s3_r};
        end else if (state_r == IDLE) begin
            hcnt_r <= '0;
        end else if (s3_r && (hcnt_r != {CNT_W{1'b1}})) begin
            hcnt_r <= hcnt_r + CNT_W'(1);
        end else begin
            hcnt_r <= hcnt_r;
        end
    end

    assign high = high_r;
`endif

endmodule

module clk_mon #(
    parameter int PE_DIV   = 8,
    parameter int CELL_DIV = 9,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             pe_clk,
    input  logic             cell_clk,
    input  logic             err_clr,
    output logic             pe_rise,
    output logic             cell_rise,
    output logic [CNT_W-1:0] pe_period,
    output logic [CNT_W-1:0] cell_period,
    output logic             pe_locked,
    output logic             cell_locked,
    output logic [1:0]       err
`ifdef CLK_MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] pe_high,
    output logic [CNT_W-1:0] cell_high
`endif
);

    logic       pe_set_s, cell_set_s;
    logic [1:0] err_r;

    clk_mon_chan #(.DIV(PE_DIV), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_pe (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .clk_in  (pe_clk),
        .rise    (pe_rise),
        .period  (pe_period),
        .locked  (pe_locked),
        .err_set (pe_set_s)
`ifdef CLK_MON_DUTY_EN
        ,
        .high    (pe_high)
`endif
    );

    clk_mon_chan #(.DIV(CELL_DIV), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) u_cell (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .clk_in  (cell_clk),
        .rise    (cell_rise),
        .period  (cell_period),
        .locked  (cell_locked),
        .err_set (cell_set_s)
`ifdef CLK_MON_DUTY_EN
        ,
        .high    (cell_high)
`endif
    );

    // Sticky error bits; a new error in the clearing cycle survives the clear
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 2'b00;
        end else begin
            err_r <= {cell_set_s, pe_set_s} | (err_r & ~{2{err_clr}});
        end
    end

    assign err = err_r;

endmodule

// File: tb/tb_clk_mon.sv
// Scoreboard bench for clk_mon: drivers queue expected post-strobe state, a monitor checks it after each strobe.

module tb_clk_mon;

    typedef struct packed {
        logic       lk;
        logic [7:0] per;
        logic       er;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pe_clk = 1'b0;
    logic       cell_clk = 1'b0;
    logic       err_clr = 1'b0;
    logic       pe_rise, cell_rise, pe_locked, cell_locked;
    logic [7:0] pe_period, cell_period;
    logic [1:0] err;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t pe_q[$];
    exp_t cell_q[$];
    logic pe_pend = 1'b0;
    logic cell_pend = 1'b0;

    clk_mon dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .pe_clk      (pe_clk),
        .cell_clk    (cell_clk),
        .err_clr     (err_clr),
        .pe_rise     (pe_rise),
        .cell_rise   (cell_rise),
        .pe_period   (pe_period),
        .cell_period (cell_period),
        .pe_locked   (pe_locked),
        .cell_locked (cell_locked),
        .err         (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One pe_clk period starting with a rise; mode 1 = err_clr collision, mode 2 = strobe latency
    task automatic drive_pe(input int per, input int mode, input logic lk, input logic [7:0] pr, input logic er);
        exp_t e;
        e.lk = lk; e.per = pr; e.er = er;
        pe_q.push_back(e);
        pe_clk = 1'b1;
        for (int c = 1; c <= per; c++) begin
            @(negedge sys_clk);
            if (c == 4) pe_clk = 1'b0;
            if (mode == 1) begin
                if (c == 3) err_clr = 1'b1;
                if (c == 4) chk("err0_set_wins", 32'(err[0]), 32'd1);
                if (c == 5) begin
                    err_clr = 1'b0;
                    chk("err_cleared", 32'(err), 32'd0);
                end
            end
            if (mode == 2 && c <= 4) chk("pe_rise_latency", 32'(pe_rise), (c == 3) ? 32'd1 : 32'd0);
        end
    endtask

    // One cell_clk period starting with a rise; mode 3 = long stall with timeout checks
    task automatic drive_cell(input int per, input int mode, input logic lk, input logic [7:0] pr, input logic er);
        exp_t e;
        e.lk = lk; e.per = pr; e.er = er;
        cell_q.push_back(e);
        cell_clk = 1'b1;
        for (int c = 1; c <= per; c++) begin
            @(negedge sys_clk);
            if (c == 4) cell_clk = 1'b0;
            if (mode == 3 && c == 21) begin
                chk("stall_locked_before", 32'(cell_locked), 32'd1);
                chk("stall_err_before", 32'(err[1]), 32'd0);
            end
            if (mode == 3 && c == 22) begin
                chk("stall_locked_after", 32'(cell_locked), 32'd0);
                chk("stall_err_after", 32'(err[1]), 32'd1);
                chk("stall_period_held", 32'(cell_period), 32'd9);
            end
        end
    endtask

    task automatic pe_script();
        drive_pe(8, 2, 1'b0, 8'd0, 1'b0);
        for (int i = 2; i <= 4; i++) drive_pe(8, 0, 1'b0, 8'd8, 1'b0);
        for (int i = 5; i <= 7; i++) drive_pe(8, 0, 1'b1, 8'd8, 1'b0);
        drive_pe(7, 0, 1'b1, 8'd8, 1'b0);
        drive_pe(8, 0, 1'b0, 8'd7, 1'b1);
        for (int i = 10; i <= 12; i++) drive_pe(8, 0, 1'b0, 8'd8, 1'b1);
        drive_pe(6, 0, 1'b1, 8'd8, 1'b1);
        drive_pe(8, 1, 1'b0, 8'd6, 1'b1);
        for (int i = 15; i <= 17; i++) drive_pe(8, 0, 1'b0, 8'd8, 1'b0);
        for (int i = 18; i <= 23; i++) drive_pe(8, 0, 1'b1, 8'd8, 1'b0);
    endtask

    task automatic cell_script();
        drive_cell(9, 0, 1'b0, 8'd0, 1'b0);
        for (int i = 2; i <= 4; i++) drive_cell(9, 0, 1'b0, 8'd9, 1'b0);
        for (int i = 5; i <= 7; i++) drive_cell(9, 0, 1'b1, 8'd9, 1'b0);
        drive_cell(49, 3, 1'b1, 8'd9, 1'b0);
        for (int i = 9; i <= 12; i++) drive_cell(9, 0, 1'b0, 8'd9, 1'b0);
        for (int i = 13; i <= 15; i++) drive_cell(9, 0, 1'b1, 8'd9, 1'b0);
    endtask

    task automatic relock_pe();
        drive_pe(8, 0, 1'b0, 8'd0, 1'b0);
        for (int i = 2; i <= 4; i++) drive_pe(8, 0, 1'b0, 8'd8, 1'b0);
        for (int i = 5; i <= 6; i++) drive_pe(8, 0, 1'b1, 8'd8, 1'b0);
    endtask

    task automatic relock_cell();
        drive_cell(9, 0, 1'b0, 8'd0, 1'b0);
        for (int i = 2; i <= 4; i++) drive_cell(9, 0, 1'b0, 8'd9, 1'b0);
        for (int i = 5; i <= 6; i++) drive_cell(9, 0, 1'b1, 8'd9, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pe_rise"}, 32'(pe_rise), 32'd0);
        chk({tag, "_cell_rise"}, 32'(cell_rise), 32'd0);
        chk({tag, "_pe_period"}, 32'(pe_period), 32'd0);
        chk({tag, "_cell_period"}, 32'(cell_period), 32'd0);
        chk({tag, "_pe_locked"}, 32'(pe_locked), 32'd0);
        chk({tag, "_cell_locked"}, 32'(cell_locked), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Monitor: one cycle after each strobe, compare against the oldest queued expectation
    always @(negedge sys_clk) begin
        if (!reset_n) begin
            pe_pend = 1'b0;
            cell_pend = 1'b0;
        end else begin
            if (pe_pend) begin
                if (pe_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL pe_unexpected_strobe: got strobe, expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = pe_q.pop_front();
                    chk("pe_locked", 32'(pe_locked), 32'(e.lk));
                    chk("pe_period", 32'(pe_period), 32'(e.per));
                    chk("pe_err", 32'(err[0]), 32'(e.er));
                end
            end
            if (cell_pend) begin
                if (cell_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL cell_unexpected_strobe: got strobe, expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = cell_q.pop_front();
                    chk("cell_locked", 32'(cell_locked), 32'(e.lk));
                    chk("cell_period", 32'(cell_period), 32'(e.per));
                    chk("cell_err", 32'(err[1]), 32'(e.er));
                end
            end
            pe_pend = pe_rise;
            cell_pend = cell_rise;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        fork
            pe_script();
            cell_script();
        join
        chk("pre_reset_pe_locked", 32'(pe_locked), 32'd1);
        chk("pre_reset_cell_locked", 32'(cell_locked), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        fork
            relock_pe();
            relock_cell();
        join
        repeat (3) @(negedge sys_clk);
        chk("pe_queue_drained", 32'(pe_q.size()), 32'd0);
        chk("cell_queue_drained", 32'(cell_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_mon.md
Name: clk_mon

Overview:
- Sits directly downstream of the LSTM clock generator, in the sys_clk domain.
- Consumes the derived pe_clk (nominal sys_clk/8) and cell_clk (nominal sys_clk/9).
- Per clock:
  - synchronises it;
  - emits single-cycle rising-edge strobes for sys_clk-domain control logic;
  - measures its period in sys_clk cycles;
  - declares lock after consecutive correct periods;
  - flags period mismatches and stalls in a sticky error register.

Parameters:
- PE_DIV, 8, expected pe_clk period in sys_clk cycles (>=4).
- CELL_DIV, 9, expected cell_clk period in sys_clk cycles (>=4).
- LOCK_CNT, 4, consecutive matching periods required for lock (>=1).
- CNT_W, 8, period counter width; must hold 2*max(PE_DIV,CELL_DIV).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pe_clk  in  1  derived PE clock; treated as asynchronous data.
- cell_clk  in  1  derived cell clock; treated as asynchronous data.
- err_clr  in  1  synchronous clear of err bits.
- pe_rise  out  1  one-cycle strobe per pe_clk rising edge.
- cell_rise  out  1  one-cycle strobe per cell_clk rising edge.
- pe_period  out  CNT_W  last measured pe_clk period.
- cell_period  out  CNT_W  last measured cell_clk period.
- pe_locked  out  1  pe_clk lock status.
- cell_locked  out  1  cell_clk lock status.
- err  out  2  sticky errors; bit0 = pe, bit1 = cell.

Behaviour:
Reset and structure:
- Reset: reset_n is asynchronous, active-low; clock is sys_clk.
- All outputs, synchronisers, counters and states go to 0 / IDLE on reset.
- Two identical channels (pe, cell), each with its own DIV.

Synchroniser and strobe:
- Each channel uses a 2-flop synchroniser plus a history flop (s1, s2, s3).
- The rise strobe is registered: s2 & ~s3 sampled.
- Latency: strobe is high for exactly one cycle after the 3rd sys_clk edge, counting the edge that first samples the input high.

Period counter:
- Counter cnt is 0 while in IDLE.
- On a rise strobe: period output <= cnt (only when the state is not IDLE), then cnt <= 1.
- Otherwise cnt increments, saturating at all-ones.
- Rises 8 cycles apart therefore measure 8.

Channel FSM:
- IDLE:
  - rise -> MEAS.
  - No period checked on the first edge.
- MEAS / LOCKING:
  - rise with cnt==DIV: match counter increments; on reaching LOCK_CNT -> LOCKED, locked <= 1 on that strobe cycle.
  - rise with cnt!=DIV: match counter <= 0, stay in LOCKING; no error is raised before lock.
- LOCKED:
  - rise with cnt!=DIV: err bit <= 1, locked <= 0, match counter <= 0 -> LOCKING.
- Timeout (any non-IDLE state):
  - cnt==2*DIV with no rise that cycle -> next edge: IDLE, cnt <= 0, locked <= 0, match counter <= 0.
  - err bit is set only if the channel was LOCKED.

Lock timing:
- From reset with a clean clock, locked rises at rise strobe number LOCK_CNT+1.

Error register:
- err_clr clears both err bits.
- Set and clear in the same cycle: set wins.
- Period outputs hold their last value across timeout and unlock.

Channel independence:
- The two channels never interact.
- Simultaneous rises on both channels are handled independently.

Reset mid-operation:
- Immediate return to the reset state, including any strobe in flight.

Optional Feature:
- Macro: CLK_MON_DUTY_EN.
- When defined:
  - adds outputs pe_high and cell_high (CNT_W each): number of sys_clk cycles the synchronised input was high in the last completed period;
  - updated on the same rise strobe as the period output; reset to 0.
  - duty is not used for lock or error.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Clean lock: pe_clk period 8 and cell_clk period 9 from reset -> pe_locked at pe strobe 5, cell_locked at cell strobe 5; pe_period=8, cell_period=9; err=0.
- Strobe latency: pe_clk rises just before sys_clk edge k -> pe_rise high only in the cycle after edge k+2.
- Mismatch after lock: one pe_clk period of 7 -> err=2'b01 and pe_locked=0 on that strobe; relock after 4 further periods of 8; err stays set.
- Stall: hold cell_clk low after lock -> 18 cycles after the last strobe cell_locked=0, err[1]=1; cell_period stays 9.
- err_clr: assert err_clr on the same cycle as a new pe mismatch -> err[0] remains 1; asserting it alone the next cycle -> err=0.
- Reset mid-operation: pull reset_n low asynchronously while both channels are locked -> all outputs 0 immediately; after release, relock per the first scenario.
